// File: rtl/gold_spread_ctrl.sv
// BPSK direct-sequence spreading controller: two 10-stage Gold LFSRs with bit handshake,
// programmable chip rate, start/stop and underrun reporting. Optional macro: GOLD_SEED_LOAD_EN.
module gold_spread_ctrl #(
  parameter int          CHIPS_PER_BIT = 1023,
  parameter int          CHIP_DIV      = 4,
  parameter logic [9:0]  SEED1         = 10'h3FF,
  parameter logic [9:0]  SEED2         = 10'h3FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       bit_in,
  input  logic       bit_valid,
`ifdef GOLD_SEED_LOAD_EN
  input  logic [9:0] seed2_in,
`endif
  output logic       bit_ready,
  output logic       chip_out,
  output logic       chip_valid,
  output logic       chip_first,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = $clog2(CHIPS_PER_BIT + 1);
  localparam int DW = $clog2(CHIP_DIV + 1);
  localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_BIT - 1);
  localparam logic [DW-1:0] LAST_DIV  = DW'(CHIP_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BIT, RUN} state_t;

  state_t        state, state_n;
  logic [9:0]    r1, r2, seed2_eff;
  logic [CW-1:0] chip_cnt, idx;
  logic [DW-1:0] div_cnt;
  logic          cur_bit, pend_bit, pend_full, stopping;
  logic          hs, eob, have_next, next_bit;
  logic          emit, emit_bit, pend_full_n, stopping_n, bit_ready_n;

`ifdef GOLD_SEED_LOAD_EN
  // An all-zero LFSR would lock up, so zero selects the all-ones phase.
  assign seed2_eff = (seed2_in == 10'h000) ? 10'h3FF : seed2_in;
`else
  assign seed2_eff = SEED2;
`endif

  assign hs        = bit_valid && bit_ready;
  // chip_cnt holds the index of the next chip; it wraps to 0 right after the last one.
  assign eob       = (state == RUN) && chip_valid && (chip_cnt == '0);
  assign have_next = pend_full || hs;
  assign next_bit  = pend_full ? pend_bit : bit_in;
  assign idx       = (state == WAIT_BIT) ? '0 : chip_cnt;

  always_comb begin
    state_n     = state;
    pend_full_n = pend_full;
    stopping_n  = stopping;
    emit        = 1'b0;
    emit_bit    = cur_bit;
    case (state)
      IDLE: if (start) begin
        state_n    = LOAD;
        stopping_n = 1'b0;
      end
      LOAD: begin
        state_n = WAIT_BIT;
        if (stop) stopping_n = 1'b1;
      end
      WAIT_BIT: if (hs) begin
        state_n  = RUN;
        emit     = 1'b1;
        emit_bit = bit_in;
        if (stop) stopping_n = 1'b1;
      end else if (stop || stopping) begin
        state_n = IDLE;
      end
      RUN: begin
        if (stop) stopping_n = 1'b1;
        if (eob) begin
          if (have_next) begin
            pend_full_n = 1'b0;
            emit_bit    = next_bit;
            emit        = (div_cnt == LAST_DIV);
          end else begin
            state_n = (stopping || stop) ? IDLE : WAIT_BIT;
          end
        end else begin
          emit = (div_cnt == LAST_DIV);
          if (hs) pend_full_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    bit_ready_n = ((state_n == WAIT_BIT) || (state_n == RUN)) && !stopping_n && !pend_full_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r1         <= SEED1;
      r2         <= SEED2;
      chip_cnt   <= '0;
      div_cnt    <= '0;
      cur_bit    <= 1'b0;
      pend_bit   <= 1'b0;
      pend_full  <= 1'b0;
      stopping   <= 1'b0;
      bit_ready  <= 1'b0;
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      chip_first <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      pend_full  <= pend_full_n;
      stopping   <= stopping_n;
      bit_ready  <= bit_ready_n;
      busy       <= (state_n != IDLE);
      chip_valid <= emit;
      chip_out   <= emit && (r1[9] ^ r2[9] ^ emit_bit);
      chip_first <= emit && ((state == WAIT_BIT) || (chip_cnt == '0));

      if (state == LOAD) begin
        r1       <= SEED1;
        r2       <= seed2_eff;
        chip_cnt <= '0;
      end else if (emit) begin
        r1       <= {r1[8:0], r1[9] ^ r1[2]};
        r2       <= {r2[8:0], r2[9] ^ r2[8] ^ r2[7] ^ r2[5] ^ r2[2] ^ r2[1]};
        chip_cnt <= (idx == LAST_CHIP) ? '0 : idx + 1'b1;
      end

      if (state == RUN) div_cnt <= (div_cnt == LAST_DIV) ? '0 : div_cnt + 1'b1;
      else              div_cnt <= '0;

      if (eob && have_next)            cur_bit  <= next_bit;
      else if (state == WAIT_BIT && hs) cur_bit  <= bit_in;
      if (state == RUN && !eob && hs)  pend_bit <= bit_in;

      if ((state == IDLE && start) || state == LOAD) underrun <= 1'b0;
      else if (eob && !have_next && !(stopping || stop)) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gold_spread_ctrl.sv
// Scoreboard bench for gold_spread_ctrl: expected chips queued at each bit handshake
// from a reference Gold model, popped and compared on every chip strobe.
module tb_gold_spread_ctrl;
  localparam int CPB = 1023;
  localparam int CD  = 4;

  logic clk = 0, reset = 1, start = 0, stop = 0, bit_in = 0, bit_valid = 0;
  logic bit_ready, chip_out, chip_valid, chip_first, busy, underrun;
  logic [9:0] seed2 = 10'h3FF;

  gold_spread_ctrl #(.CHIPS_PER_BIT(CPB), .CHIP_DIV(CD), .SEED1(10'h3FF), .SEED2(10'h3FF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bit_in(bit_in), .bit_valid(bit_valid),
`ifdef GOLD_SEED_LOAD_EN
    .seed2_in(seed2),
`endif
    .bit_ready(bit_ready), .chip_out(chip_out), .chip_valid(chip_valid),
    .chip_first(chip_first), .busy(busy), .underrun(underrun));

  always #5 clk = ~clk;

  typedef struct {logic chip; logic first; logic gap;} exp_t;
  exp_t q[$];
  exp_t e;
  int   nerr = 0, nchk = 0, cyc = 0, last_cyc = 0, nstrobe = 0, cap_n = 0;
  logic cap [0:2047];
  logic run1 [0:1022];
  logic [9:0] m1, m2;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && chip_valid) begin
      if (q.size() == 0) chk("unexp_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("chip", chip_out, e.chip);
        chk("first", chip_first, e.first);
        if (e.gap) chk("gap", cyc - last_cyc, CD);
      end
      last_cyc = cyc;
      nstrobe++;
      if (cap_n < 2048) cap[cap_n] = chip_out;
      cap_n++;
    end
  end

  task automatic push_bit(input logic b, input logic gapless);
    logic g;
    for (int k = 0; k < CPB; k++) begin
      g = m1[9] ^ m2[9];
      q.push_back('{chip: g ^ b, first: (k == 0), gap: (k != 0) || gapless});
      m1 = {m1[8:0], m1[9] ^ m1[2]};
      m2 = {m2[8:0], m2[9] ^ m2[8] ^ m2[7] ^ m2[5] ^ m2[2] ^ m2[1]};
    end
  endtask

  task automatic send_bit(input logic b, input logic gapless, input logic chk_lat);
    int i;
    @(negedge clk);
    bit_in = b; bit_valid = 1;
    i = 0;
    while (!bit_ready && i < 20000) begin @(negedge clk); i++; end
    chk("ready_wait", bit_ready, 1);
    push_bit(b, gapless);
    @(posedge clk); #1 bit_valid = 0;
    if (chk_lat) begin
      @(negedge clk); #1;
      chk("lat_valid", chip_valid, 1);
      chk("lat_first", chip_first, 1);
    end
  endtask

  task automatic wait_q(input int left, input int maxc);
    int i = 0;
    while (q.size() > left && i < maxc) begin @(negedge clk); #1; i++; end
    chk("drain", q.size() > left, 0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    m1 = 10'h3FF;
`ifdef GOLD_SEED_LOAD_EN
    m2 = (seed2 == 10'h000) ? 10'h3FF : seed2;
`else
    m2 = 10'h3FF;
`endif
    #1;
    chk("load_busy", busy, 1);
    chk("load_ready", bit_ready, 0);
    chk("load_urun", underrun, 0);
    @(negedge clk); #1;
    chk("wait_ready", bit_ready, 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, bit_ready, 0);
    chk({tag, "_chip"}, chip_out, 0);
    chk({tag, "_valid"}, chip_valid, 0);
    chk({tag, "_first"}, chip_first, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_urun"}, underrun, 0);
  endtask

  initial begin
    int bad;
    int diff;
    repeat (3) @(negedge clk);
    #1 chk_rst("rst");
    reset = 0;
    @(negedge clk); #1 chk_rst("idle");

    // two bits, second accepted early: gapless, complemented, no underrun
    do_start();
    cap_n = 0; nstrobe = 0;
    send_bit(0, 0, 1);
    send_bit(1, 1, 0);
    wait_q(1, 20000);
    chk("urun_run", underrun, 0);
    wait_q(0, 100);
    for (int i = 0; i < CPB; i++) run1[i] = cap[i];
    bad = 0;
    for (int i = 0; i < 10; i++) if (cap[i] !== 1'b0) bad++;
    chk("first10_zero", bad, 0);
    bad = 0;
    for (int i = 0; i < CPB; i++) if (cap[CPB + i] !== ~cap[i]) bad++;
    chk("complement", bad, 0);
    chk("strobes", nstrobe, 2 * CPB);

    // underrun after the last chip, then resume with LFSR continuing
    @(negedge clk); #1;
    chk("urun_set", underrun, 1);
    chk("urun_ready", bit_ready, 1);
    chk("urun_valid", chip_valid, 0);
    repeat (20) @(negedge clk);
    #1 chk("urun_quiet", chip_valid, 0);
    send_bit(1, 0, 1);
    wait_q(0, 20000);

    // stop mid-bit with a pending bit held
    send_bit(0, 0, 1);
    send_bit(1, 1, 0);
    repeat (100) @(negedge clk);
    stop = 1;
    @(negedge clk); stop = 0;
    #1 chk("stop_ready", bit_ready, 0);
    wait_q(0, 20000);
    chk("stop_last_busy", busy, 1);
    chk("stop_last_valid", chip_valid, 1);
    @(negedge clk); #1;
    chk("stop_busy", busy, 0);
    chk("stop_valid", chip_valid, 0);
    chk("stop_ready2", bit_ready, 0);

    // reset at chip 500, then a fresh run repeats the first run
    do_start();
    cap_n = 0;
    send_bit(0, 0, 1);
    begin
      int i = 0;
      while (cap_n < 500 && i < 5000) begin @(negedge clk); #1; i++; end
    end
    chk("reach500", cap_n >= 500, 1);
    reset = 1;
    #1 chk_rst("midrst");
    q.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    do_start();
    cap_n = 0;
    send_bit(0, 0, 1);
    wait_q(0, 20000);
    bad = 0;
    for (int i = 0; i < CPB; i++) if (cap[i] !== run1[i]) bad++;
    chk("rerun_same", bad, 0);

`ifdef GOLD_SEED_LOAD_EN
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
    @(negedge clk); #1 chk("to_idle", busy, 0);
    seed2 = 10'h000;
    do_start();
    cap_n = 0;
    send_bit(0, 0, 1);
    wait_q(0, 20000);
    bad = 0;
    for (int i = 0; i < CPB; i++) if (cap[i] !== run1[i]) bad++;
    chk("seed0_same", bad, 0);
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
    @(negedge clk);
    seed2 = 10'h155;
    do_start();
    cap_n = 0;
    send_bit(0, 0, 1);
    send_bit(0, 1, 0);
    wait_q(0, 20000);
    diff = 0; bad = 0;
    for (int i = 0; i < CPB; i++) begin
      if (cap[i] !== run1[i]) diff++;
      if (cap[i] !== cap[CPB + i]) bad++;
    end
    chk("seed155_diff", diff != 0, 1);
    chk("seed155_period", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: sim time limit reached");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "timeout");
  end
endmodule
